memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute; consumes alu_result/reg_data2/rd/funct3/opcode.
//  Runs loads/stores on a req/gnt/rvalid data-memory port; aligns, strobes and extends data.
//  Passes non-memory results to writeback through a register; back-pressures execute while busy.
// PARAMETERS
//  WIDTH     32   datapath width (from all_pkgs; the design is 32-bit only)
//  MAX_WAIT  255  cycles allowed in REQ or WAIT before bus_err; counter is $clog2(MAX_WAIT+1) bits
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  ex_valid      in   1      execute outputs valid this cycle
//  ex_ready      out  1      stage can accept; 1 only in IDLE
//  alu_result    in   WIDTH  ALU result / effective address
//  reg_data2     in   WIDTH  store data
//  rd            in   5      destination register
//  funct3        in   3      load/store size and sign
//  opcode        in   7      instruction opcode
//  dmem_req      out  1      memory request
//  dmem_we       out  1      1 = store
//  dmem_addr     out  WIDTH  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata    out  WIDTH  lane-replicated store data
//  dmem_wstrb    out  4      byte strobes
//  dmem_gnt      in   1      request accepted
//  dmem_rvalid   in   1      load data valid
//  dmem_rdata    in   WIDTH  load data
//  wb_valid      out  1      writeback result valid (1-cycle pulse)
//  wb_we         out  1      write register file
//  wb_rd         out  5      writeback destination
//  wb_data       out  WIDTH  writeback data
//  misalign_err  out  1      1-cycle pulse: misaligned access dropped
//  bus_err       out  1      1-cycle pulse: memory timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output 0 except ex_ready=1; wait counter=0.
//  FSM: IDLE, REQ, WAIT.
//   IDLE: ex_valid & non-mem opcode -> next cycle wb_valid=1, wb_data=alu_result, wb_we=(rd!=0).
//    ex_valid & OP_LOAD/OP_STORE & aligned -> capture addr/data/rd/funct3, go to REQ.
//    Misaligned (H: addr[0]; W: addr[1:0]!=0) -> no request; next cycle wb_valid=1, wb_we=0,
//    misalign_err=1; stay in IDLE.
//   REQ: dmem_req=1; addr/we/wdata/wstrb held stable until gnt. On gnt: store -> IDLE,
//    wb_valid=1 and wb_we=0 next cycle; load -> WAIT, or complete at once if rvalid is also 1.
//   WAIT: on rvalid -> IDLE; next cycle wb_valid=1, wb_data=extracted load, wb_we=(rd!=0).
//  Timeout: counter clears on entering REQ or WAIT and counts each cycle spent there.
//   At MAX_WAIT: bus_err=1, wb_valid=1, wb_we=0, state=IDLE, dmem_req drops.
//  ex_ready=(state==IDLE). In IDLE a new op is accepted every cycle, so ALU ops run back-to-back.
//  Latency: ALU op 1 cycle; store 2 with gnt in first REQ cycle; load 3 with gnt then rvalid next.
//  Store: SB wstrb=4'b0001<<a[1:0], wdata={4{d[7:0]}}; SH wstrb=4'b0011<<{a[1],1'b0},
//   wdata={2{d[15:0]}}; SW wstrb=4'b1111.
//  Load: select lane by captured a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
//  rvalid in IDLE/REQ without a pending load is ignored. rd==0 never asserts wb_we.
//  Reset mid-transaction: dmem_req drops at once; a later rvalid/gnt is ignored.
// STRUCTURE
//  all_pkgs: OP_LOAD=7'b0000011, OP_STORE=7'b0100011, LS_B/H/W/BU/HU funct3 encodings,
//   mem_state_t enum {IDLE,REQ,WAIT}.
//  Sub-module: load_align (combinational lane select + sign/zero extension).
// TESTING
//  ALU op alu_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_we=1, ex_ready stays 1.
//  SB addr=0x103, data=0xAB, gnt after 2 cycles -> dmem_addr=0x100, wstrb=4'b1000,
//   wdata=0xABABABAB held 3 cycles; wb_valid with wb_we=0.
//  LH addr=0x102, rdata=0x8001_0000, rvalid 1 cycle after gnt -> wb_data=0xFFFF8001;
//   LHU -> 0x00008001.
//  LW addr=0x101 -> no dmem_req; misalign_err pulse; wb_valid=1, wb_we=0.
//  Load, gnt never asserted, MAX_WAIT=8 -> bus_err after 8 REQ cycles; back to IDLE, ex_ready=1.
//  rst low while in WAIT, then rvalid -> outputs 0, state IDLE, no wb_valid.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: opcodes, load/store size encodings, FSM states and store lane helpers.
package memory_stage_pkg;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
   function automatic logic [3:0] st_strb(input logic [1:0] sz, input logic [1:0] a);
      return sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
   endfunction
   function automatic logic [31:0] st_data(input logic [1:0] sz, input logic [31:0] d);
      return sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
   endfunction
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
   endfunction
endpackage

// File: rtl/memory_stage_load_align.sv
// memory_stage_load_align: picks the addressed lane of a load word and sign/zero extends it.
module memory_stage_load_align
   import memory_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b    = rdata[{off, 3'b000} +: 8];
      h    = off[1] ? rdata[31:16] : rdata[15:0];
      data = funct3[1:0] == 2'b00 ? {{24{~funct3[2] & b[7]}}, b} :
             funct3[1:0] == 2'b01 ? {{16{~funct3[2] & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: executes loads/stores over a req/gnt/rvalid port and forwards ALU results to writeback.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] reg_data2,
   input  logic [4:0]       rd,
   input  logic [2:0]       funct3,
   input  logic [6:0]       opcode,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [3:0]       dmem_wstrb,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             misalign_err,
   output logic             bus_err
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   mem_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, ld_data;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [4:0]       rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic             we_q, we_d, wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
   logic             mis_q, mis_d, berr_q, berr_d;
   memory_stage_load_align u_align (
      .rdata (dmem_rdata),
      .off   (off_q),
      .funct3(funct3_q),
      .data  (ld_data)
   );
   always_comb begin
      state_d    = state_q;
      cnt_inc    = cnt_q + CW'(1);
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      we_d       = we_q;
      off_d      = off_q;
      funct3_d   = funct3_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      mis_d      = 1'b0;
      berr_d     = 1'b0;
      case (state_q)
         IDLE: if (ex_valid) begin
            if (opcode != OP_LOAD && opcode != OP_STORE) begin
               wb_valid_d = 1'b1;
               wb_we_d    = rd != 5'd0;
               wb_rd_d    = rd;
               wb_data_d  = alu_result;
            end else if (misaligned(funct3[1:0], alu_result[1:0])) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd;
               wb_data_d  = '0;
               mis_d      = 1'b1;
            end else begin
               state_d  = REQ;
               cnt_d    = '0;
               we_d     = opcode == OP_STORE;
               addr_d   = {alu_result[WIDTH-1:2], 2'b00};
               wdata_d  = st_data(funct3[1:0], reg_data2);
               wstrb_d  = opcode == OP_STORE ? st_strb(funct3[1:0], alu_result[1:0]) : 4'b0000;
               off_d    = alu_result[1:0];
               funct3_d = funct3;
               rd_d     = rd;
            end
         end
         default: begin
            cnt_d   = cnt_inc;
            wb_rd_d = rd_q;
            // A grant with rvalid in the same cycle completes the load without visiting WAIT.
            if (state_q == REQ && dmem_gnt && we_q) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_data_d  = '0;
            end else if (dmem_rvalid && (state_q == WAIT || dmem_gnt)) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_we_d    = rd_q != 5'd0;
               wb_data_d  = ld_data;
            end else if (state_q == REQ && dmem_gnt) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else if (cnt_inc == CW'(MAX_WAIT)) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_data_d  = '0;
               berr_d     = 1'b1;
            end
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         we_q       <= 1'b0;
         off_q      <= '0;
         funct3_q   <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         mis_q      <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         we_q       <= we_d;
         off_q      <= off_d;
         funct3_q   <= funct3_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         mis_q      <= mis_d;
         berr_q     <= berr_d;
      end
   end
   assign ex_ready     = state_q == IDLE;
   assign dmem_req     = state_q == REQ;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_wstrb   = wstrb_q;
   assign wb_valid     = wb_valid_q;
   assign wb_we        = wb_we_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = mis_q;
   assign bus_err      = berr_q;
endmodule
